// File: rtl/wbm_arb2.sv
// Two-master Wishbone arbiter onto one slave bus: fixed or round-robin priority, no pre-emption.
// Optional watchdog abort on a stalled grant is enabled with `define WBM_ARB_TIMEOUT_EN.
module wbm_arb2 #(
    parameter int TMO_CYC = 255
) (
    input  logic        app_clk,
    input  logic        srst,
    input  logic        cfg_pri_fix,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_adr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   own0, own1, own_stb, tmo;

`ifdef WBM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
    logic [7:0] wdog_q, wdog_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^8'(TMO_CYC);
`endif

    assign own0    = (state_q == GNT0);
    assign own1    = (state_q == GNT1);
    assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        tmo        = 1'b0;
`ifdef WBM_ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef WBM_ARB_TIMEOUT_EN
                wdog_d = 8'd0;
`endif
                // Round-robin favours whichever master did not finish last.
                if (m0_stb_i && m1_stb_i)
                    state_d = (cfg_pri_fix || last_gnt_q) ? GNT0 : GNT1;
                else if (m0_stb_i)
                    state_d = GNT0;
                else if (m1_stb_i)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (!own_stb) begin
                    state_d = IDLE;
                end else if (s_ack_i || s_err_i) begin
                    state_d    = IDLE;
                    last_gnt_d = own1;
                end else begin
`ifdef WBM_ARB_TIMEOUT_EN
                    if (wdog_q == TMO_LIM) begin
                        tmo        = 1'b1;
                        state_d    = IDLE;
                        last_gnt_d = own1;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = own_stb & ~tmo;
        s_stb_o  = own_stb & ~tmo;
        s_we_o   = 1'b0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        if (own0) begin
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (own1) begin
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
        m0_ack_o = own0 & s_ack_i;
        m1_ack_o = own1 & s_ack_i;
        m0_err_o = own0 & (s_err_i | tmo);
        m1_err_o = own1 & (s_err_i | tmo);
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        grant_o  = {own1, own0};
    end

    always_ff @(posedge app_clk) begin
        if (srst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
`ifdef WBM_ARB_TIMEOUT_EN
            wdog_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
`ifdef WBM_ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_wbm_arb2.sv
// Directed self-checking bench for wbm_arb2 (instantiated with TMO_CYC=4).
module tb_wbm_arb2;

    logic        app_clk = 1'b0;
    logic        srst, cfg_pri_fix;
    logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 app_clk = ~app_clk;

    wbm_arb2 #(.TMO_CYC(4)) dut (
        .app_clk(app_clk), .srst(srst), .cfg_pri_fix(cfg_pri_fix),
        .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
        .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
        .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .grant_o(grant_o)
    );

    task automatic tick;
        @(posedge app_clk);
        #1;
    endtask

    task automatic test_reset;
        srst = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        tick; tick;
        #1;
        n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant_o); end
        n_chk++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL reset_bus got %b want 00", {s_cyc_o, s_stb_o}); end
        n_chk++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", m0_ack_o); end
        n_chk++; if (s_adr_o !== 32'd0) begin n_fail++; $display("FAIL reset_adr got %h want 0", s_adr_o); end
        srst = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        tick;
    endtask

    task automatic test_single;
        m0_adr_i = 32'h1000_0040; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_dat_i = 32'h1111_2222;
        s_dat_i = 32'hCAFE_F00D;
        m0_stb_i = 1'b1;
        #1;
        n_chk++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_c0_stb got %b want 0", s_stb_o); end
        tick;
        n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", grant_o); end
        n_chk++; if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL single_c1_stb got %b%b want 11", s_cyc_o, s_stb_o); end
        n_chk++; if (s_adr_o !== 32'h1000_0040 || s_sel_o !== 4'hF) begin n_fail++; $display("FAIL single_mux got %h/%h want 10000040/f", s_adr_o, s_sel_o); end
        tick;
        n_chk++; if (s_stb_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_c2 got stb %b ack %b want 1 0", s_stb_o, m0_ack_o); end
        tick;
        s_ack_i = 1'b1;
        #1;
        n_chk++; if (s_stb_o !== 1'b1 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_c3 got stb %b ack0 %b ack1 %b want 1 1 0", s_stb_o, m0_ack_o, m1_ack_o); end
        n_chk++; if (m0_dat_o !== 32'hCAFE_F00D || m1_dat_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL single_rdata got %h/%h want cafef00d", m0_dat_o, m1_dat_o); end
        tick;
        s_ack_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        n_chk++; if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_end got gnt %b stb %b ack %b want 00 0 0", grant_o, s_stb_o, m0_ack_o); end
        tick;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        srst = 1'b1; tick; srst = 1'b0;
        cfg_pri_fix = 1'b0;
        m1_adr_i = 32'h2000_0080; m1_we_i = 1'b1; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'h3;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++; if (grant_o !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", i, grant_o, exp_g[i]); end
            if (exp_g[i] == 2'b10) begin
                n_chk++; if (s_adr_o !== 32'h2000_0080 || s_we_o !== 1'b1 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 4'h3) begin
                    n_fail++; $display("FAIL rr_mux1 got %h %b %h %h want 20000080 1 deadbeef 3", s_adr_o, s_we_o, s_dat_o, s_sel_o); end
            end
            s_ack_i = 1'b1;
            #1;
            n_chk++; if ({m1_ack_o, m0_ack_o} !== exp_g[i]) begin n_fail++; $display("FAIL rr_ack%0d got %b want %b", i, {m1_ack_o, m0_ack_o}, exp_g[i]); end
            tick;
            s_ack_i = 1'b0;
            #1;
            n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rr_dead%0d got %b want 00", i, grant_o); end
        end
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        tick;
    endtask

    task automatic test_fixed;
        cfg_pri_fix = 1'b1;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL fix_grant%0d got %b want 01", i, grant_o); end
            s_ack_i = 1'b1;
            tick;
            s_ack_i = 1'b0;
        end
        m0_stb_i = 1'b0;
        tick;
        n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL fix_m1 got %b want 10", grant_o); end
        s_ack_i = 1'b1;
        tick;
        s_ack_i = 1'b0; m1_stb_i = 1'b0; cfg_pri_fix = 1'b0;
        tick;
    endtask

    task automatic test_abort_err;
        m1_stb_i = 1'b1;
        tick;
        n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL abort_grant got %b want 10", grant_o); end
        m1_stb_i = 1'b0;
        #1;
        n_chk++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL abort_stb got %b want 00", {s_cyc_o, s_stb_o}); end
        tick;
        n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL abort_idle got %b want 00", grant_o); end
        m0_stb_i = 1'b1;
        tick;
        s_err_i = 1'b1;
        #1;
        n_chk++; if ({m1_err_o, m0_err_o, m0_ack_o} !== 3'b010) begin n_fail++; $display("FAIL err_route got %b want 010", {m1_err_o, m0_err_o, m0_ack_o}); end
        tick;
        s_err_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        n_chk++; if (grant_o !== 2'b00 || m0_err_o !== 1'b0) begin n_fail++; $display("FAIL err_end got %b/%b want 00/0", grant_o, m0_err_o); end
        tick;
    endtask

    task automatic test_reset_mid;
        m0_stb_i = 1'b1;
        tick;
        n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rmid_grant got %b want 01", grant_o); end
        srst = 1'b1; s_ack_i = 1'b1;
        tick;
        n_chk++; if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rmid_out got gnt %b stb %b cyc %b ack %b want 00 0 0 0", grant_o, s_stb_o, s_cyc_o, m0_ack_o); end
        srst = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1; cfg_pri_fix = 1'b0;
        tick;
        n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rmid_lastgnt got %b want 01", grant_o); end
        s_ack_i = 1'b1;
        tick;
        s_ack_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        tick;
    endtask

    task automatic test_watchdog;
        m1_stb_i = 1'b1;
        tick;
`ifdef WBM_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            n_chk++; if (m1_err_o !== 1'b0 || s_stb_o !== 1'b1) begin n_fail++; $display("FAIL wd_wait%0d got err %b stb %b want 0 1", c, m1_err_o, s_stb_o); end
            tick;
        end
        n_chk++; if ({m1_err_o, m0_err_o, s_stb_o} !== 3'b100) begin n_fail++; $display("FAIL wd_term got %b want 100", {m1_err_o, m0_err_o, s_stb_o}); end
        tick;
        n_chk++; if (grant_o !== 2'b00 || m1_err_o !== 1'b0) begin n_fail++; $display("FAIL wd_idle got %b/%b want 00/0", grant_o, m1_err_o); end
        tick;
        for (int c = 0; c < 4; c++) tick;
        s_ack_i = 1'b1;
        #1;
        n_chk++; if ({m1_ack_o, m1_err_o} !== 2'b10) begin n_fail++; $display("FAIL wd_ackwin got %b want 10", {m1_ack_o, m1_err_o}); end
`else
        for (int c = 0; c < 10; c++) begin
            n_chk++; if (grant_o !== 2'b10 || m1_err_o !== 1'b0) begin n_fail++; $display("FAIL nowd_hold%0d got %b/%b want 10/0", c, grant_o, m1_err_o); end
            tick;
        end
        s_ack_i = 1'b1;
        #1;
        n_chk++; if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL nowd_ack got %b want 1", m1_ack_o); end
`endif
        tick;
        s_ack_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL wd_end got %b want 00", grant_o); end
        tick;
    endtask

    initial begin
        srst = 1'b1; cfg_pri_fix = 1'b0;
        m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_fixed;
        test_abort_err;
        test_reset_mid;
        test_watchdog;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
